// File: rtl/jellyvl_etherneco_packet_rx.sv
// Etherneco ring RX parser: header extraction, payload streaming, FCS (CRC-32) check.
// Latency: header/payload outputs and start/end pulses registered, 1 cycle after the input byte.
// Backpressure: none; one byte accepted on every s_rx_valid cycle.
module jellyvl_etherneco_packet_rx #(
  parameter int PREAMBLE_MAX = 7,
  parameter bit CRC_CHECK    = 1'b1
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        s_rx_first,
  input  logic        s_rx_last,
  input  logic [7:0]  s_rx_data,
  input  logic        s_rx_valid,
  output logic        m_rx_start,
  output logic        m_rx_end,
  output logic        m_rx_error,
  output logic [15:0] m_rx_length,
  output logic [7:0]  m_rx_type,
  output logic [7:0]  m_rx_node,
  output logic        m_payload_first,
  output logic        m_payload_last,
  output logic [7:0]  m_payload_data,
  output logic        m_payload_valid
);

  localparam logic [31:0] POLY    = 32'h04C11DB7;
  localparam logic [7:0]  PRE_MAX = 8'(PREAMBLE_MAX);

  typedef enum logic [2:0] {
    ST_IDLE, ST_PREAMBLE, ST_LENGTH, ST_TYPE, ST_NODE, ST_PAYLOAD, ST_FCS, ST_WAIT
  } state_t;

  // CRC-32, MSB-first, non-reflected; restarted from all-ones on the LEN low byte.
  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      r = {r[30:0], 1'b0} ^ (((r[31] ^ d[i]) == 1'b1) ? POLY : 32'h0);
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] remain_q, remain_d;
  logic [31:0] crc_q, crc_d;
  logic [23:0] fcs_q, fcs_d;
  logic        start_q, start_d;
  logic        end_q, end_d;
  logic        error_q, error_d;
  logic [15:0] length_q, length_d;
  logic [7:0]  type_q, type_d;
  logic [7:0]  node_q, node_d;
  logic        pfirst_q, pfirst_d;
  logic        plast_q, plast_d;
  logic [7:0]  pdata_q, pdata_d;
  logic        pvalid_q, pvalid_d;
  logic        err_c;

  // Next-state and output decode; only valid bytes advance the parser.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    remain_d = remain_q;
    crc_d    = crc_q;
    fcs_d    = fcs_q;
    start_d  = 1'b0;
    end_d    = 1'b0;
    error_d  = 1'b0;
    length_d = length_q;
    type_d   = type_q;
    node_d   = node_q;
    pfirst_d = 1'b0;
    plast_d  = 1'b0;
    pdata_d  = pdata_q;
    pvalid_d = 1'b0;
    err_c    = 1'b0;

    if (s_rx_valid) begin
      if (s_rx_first && state_q != ST_IDLE && state_q != ST_WAIT) begin
        // A new frame start aborts the current one; a 0x55 start is reused.
        end_d   = 1'b1;
        error_d = 1'b1;
        if (s_rx_data == 8'h55 && !s_rx_last) begin
          state_d = ST_PREAMBLE;
          cnt_d   = 8'd1;
        end else begin
          state_d = s_rx_last ? ST_IDLE : ST_WAIT;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (s_rx_first && !s_rx_last && s_rx_data == 8'h55) begin
              state_d = ST_PREAMBLE;
              cnt_d   = 8'd1;
            end
          end
          ST_PREAMBLE: begin
            if (s_rx_last) begin
              err_c = 1'b1;
            end else if (s_rx_data == 8'h55) begin
              if (cnt_q >= PRE_MAX) err_c = 1'b1;
              else                  cnt_d = cnt_q + 8'd1;
            end else if (s_rx_data == 8'hD5) begin
              state_d = ST_LENGTH;
              cnt_d   = 8'd0;
              start_d = 1'b1;
            end else begin
              err_c = 1'b1;
            end
          end
          ST_LENGTH: begin
            if (s_rx_last) begin
              err_c = 1'b1;
            end else if (cnt_q == 8'd0) begin
              length_d[7:0] = s_rx_data;
              crc_d         = crc_next(32'hFFFF_FFFF, s_rx_data);
              cnt_d         = 8'd1;
            end else begin
              length_d[15:8] = s_rx_data;
              crc_d          = crc_next(crc_q, s_rx_data);
              state_d        = ST_TYPE;
            end
          end
          ST_TYPE: begin
            if (s_rx_last) begin
              err_c = 1'b1;
            end else begin
              type_d  = s_rx_data;
              crc_d   = crc_next(crc_q, s_rx_data);
              state_d = ST_NODE;
            end
          end
          ST_NODE: begin
            if (s_rx_last) begin
              err_c = 1'b1;
            end else begin
              node_d   = s_rx_data;
              crc_d    = crc_next(crc_q, s_rx_data);
              remain_d = length_q;
              state_d  = ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            if (s_rx_last) begin
              err_c = 1'b1;
            end else begin
              pvalid_d = 1'b1;
              pdata_d  = s_rx_data;
              pfirst_d = (remain_q == length_q);
              plast_d  = (remain_q == 16'd0);
              crc_d    = crc_next(crc_q, s_rx_data);
              if (remain_q == 16'd0) begin
                state_d = ST_FCS;
                cnt_d   = 8'd0;
              end else begin
                remain_d = remain_q - 16'd1;
              end
            end
          end
          ST_FCS: begin
            if (cnt_q[1:0] == 2'd3) begin
              if (s_rx_last) begin
                state_d = ST_IDLE;
                end_d   = 1'b1;
                error_d = CRC_CHECK && ({s_rx_data, fcs_q} != crc_q);
              end else begin
                err_c = 1'b1;
              end
            end else if (s_rx_last) begin
              err_c = 1'b1;
            end else begin
              case (cnt_q[1:0])
                2'd0:    fcs_d[7:0]   = s_rx_data;
                2'd1:    fcs_d[15:8]  = s_rx_data;
                default: fcs_d[23:16] = s_rx_data;
              endcase
              cnt_d = cnt_q + 8'd1;
            end
          end
          ST_WAIT: begin
            if (s_rx_last) state_d = ST_IDLE;
          end
          default: state_d = ST_IDLE;
        endcase

        // Single error report, then drop the rest of the frame.
        if (err_c) begin
          end_d   = 1'b1;
          error_d = 1'b1;
          state_d = s_rx_last ? ST_IDLE : ST_WAIT;
        end
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      remain_q <= 16'd0;
      crc_q    <= 32'd0;
      fcs_q    <= 24'd0;
      start_q  <= 1'b0;
      end_q    <= 1'b0;
      error_q  <= 1'b0;
      length_q <= 16'd0;
      type_q   <= 8'd0;
      node_q   <= 8'd0;
      pfirst_q <= 1'b0;
      plast_q  <= 1'b0;
      pdata_q  <= 8'd0;
      pvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      remain_q <= remain_d;
      crc_q    <= crc_d;
      fcs_q    <= fcs_d;
      start_q  <= start_d;
      end_q    <= end_d;
      error_q  <= error_d;
      length_q <= length_d;
      type_q   <= type_d;
      node_q   <= node_d;
      pfirst_q <= pfirst_d;
      plast_q  <= plast_d;
      pdata_q  <= pdata_d;
      pvalid_q <= pvalid_d;
    end
  end

  assign m_rx_start      = start_q;
  assign m_rx_end        = end_q;
  assign m_rx_error      = error_q;
  assign m_rx_length     = length_q;
  assign m_rx_type       = type_q;
  assign m_rx_node       = node_q;
  assign m_payload_first = pfirst_q;
  assign m_payload_last  = plast_q;
  assign m_payload_data  = pdata_q;
  assign m_payload_valid = pvalid_q;

endmodule
